// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types and width helpers for the output-stationary systolic array
//   sequencer (systolic_ctrl) and its per-lane skew generator (skew_lane).
//
//   Contents:
//     state_t        sequencer states IDLE, CLEAR, FEED, DRAIN, READOUT
//     kw(n)          lane inner-index / row / column width, max(1, clog2(n))
//     tw(n)          step counter width, clog2(3n)
//     rw(n)          readout index width, clog2(n*n+1)
//     acc_w(width)   accumulator / result width, 2*width
//     feed_cyc(n)    FEED duration, 2n-1 cycles
//     drain_cyc(n)   DRAIN duration, n-1 cycles
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        READOUT
    } state_t;

    function automatic int kw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tw(input int n);
        return $clog2(3 * n);
    endfunction

    function automatic int rw(input int n);
        return $clog2(n * n + 1);
    endfunction

    function automatic int acc_w(input int width);
        return 2 * width;
    endfunction

    function automatic int feed_cyc(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_cyc(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
//   Combinational enable and inner index for one operand lane of the array.
//   Lane LANE (row LANE of A, column LANE of B) injects operand k = t - LANE
//   while LANE <= t < LANE + N during FEED; at all other times it is idle
//   and reports k = 0.
//
//   Ports:
//     state  in   state_t   sequencer state
//     t      in   tw(N)     FEED/DRAIN step counter
//     en     out  1         lane injects a real operand this cycle
//     k      out  kw(N)     inner index of the injected operand
// -----------------------------------------------------------------------------
module skew_lane
    import systolic_pkg::*;
#(
    parameter int N    = 4,
    parameter int LANE = 0
) (
    input  state_t             state,
    input  logic [tw(N)-1:0]   t,
    output logic               en,
    output logic [kw(N)-1:0]   k
);

    localparam int KW = kw(N);

    always_comb begin
        // NOTE: both outputs get a default before any condition so every path
        // assigns them and no latch is inferred.
        en = 1'b0;
        k  = '0;
        if (state == FEED && int'(t) >= LANE && int'(t) < LANE + N) begin
            en = 1'b1;
            k  = KW'(int'(t) - LANE);
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer for an NxN output-stationary PE grid. On start it clears the
//   grid for one cycle, drives skewed operand-lane enables and inner indices
//   for 2N-1 cycles, waits N-1 cycles for the wavefront to drain, then streams
//   the N*N accumulators out in row-major order over a valid/ready port.
//
//   Parameters:
//     N       array dimension (rows = cols = inner length), N >= 1
//     WIDTH   operand width; results are 2*WIDTH wide
//
//   Ports:
//     clk        in   1             clock
//     rst        in   1             synchronous, active-high reset
//     start      in   1             request one multiply (taken only in IDLE)
//     busy       out  1             high in every state except IDLE
//     done       out  1             one-cycle pulse after the last result
//     arr_clr    out  1             clears the PE grid
//     lane_en    out  N             per-lane real-operand enable
//     lane_k     out  N*KW          per-lane inner index, lane i at [i*KW+:KW]
//     arr_c      in   N*N*2*WIDTH   PE accumulators, PE(r,c) at (r*N+c)
//     res_valid  out  1             result word available
//     res_ready  in   1             sink accepts result
//     res_data   out  2*WIDTH       selected accumulator
//     res_row    out  KW            row of res_data
//     res_col    out  KW            column of res_data
//     perf_cycles out 32            busy-cycle count (only with
//                                   SYSTOLIC_CTRL_PERF_EN defined)
//
//   Build option: define SYSTOLIC_CTRL_PERF_EN to add perf_cycles, which is
//   cleared on rst and on start acceptance, counts every busy cycle and
//   saturates at all-ones.
// -----------------------------------------------------------------------------
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      arr_clr,
    output logic [N-1:0]              lane_en,
    output logic [N*kw(N)-1:0]        lane_k,
    input  logic [N*N*2*WIDTH-1:0]    arr_c,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*WIDTH-1:0]        res_data,
    output logic [kw(N)-1:0]          res_row,
    output logic [kw(N)-1:0]          res_col
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam int KW        = kw(N);
    localparam int TW        = tw(N);
    localparam int RW        = rw(N);
    localparam int ACC_W     = acc_w(WIDTH);
    localparam int FEED_CYC  = feed_cyc(N);
    localparam int DRAIN_CYC = drain_cyc(N);

    state_t        state;
    logic [TW-1:0] t;     // step counter across FEED and DRAIN
    logic [RW-1:0] r;     // row-major readout index

    // -------------------------------------------------------------------------
    // Sequencer with registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            r         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_clr   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            arr_clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                        t       <= '0;
                        r       <= '0;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                end
                FEED: begin
                    if (t == TW'(FEED_CYC - 1)) begin
                        if (DRAIN_CYC == 0) begin
                            // Single-PE array: the only product is already
                            // accumulated, so go straight to readout.
                            state     <= READOUT;
                            res_valid <= 1'b1;
                            t         <= '0;
                        end else begin
                            state <= DRAIN;
                            t     <= t + TW'(1);
                        end
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DRAIN: begin
                    // Last product reaches PE(N-1,N-1) at the edge that ends
                    // step 3N-3.
                    if (t == TW'(FEED_CYC + DRAIN_CYC - 1)) begin
                        state     <= READOUT;
                        res_valid <= 1'b1;
                        t         <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                READOUT: begin
                    if (res_ready) begin
                        if (r == RW'(N * N - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            res_valid <= 1'b0;
                            r         <= '0;
                        end else begin
                            r <= r + RW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane skew generation
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(
            .N    (N),
            .LANE (i)
        ) u_lane (
            .state (state),
            .t     (t),
            .en    (lane_en[i]),
            .k     (lane_k[i*KW +: KW])
        );
    end

    // -------------------------------------------------------------------------
    // Result mux: row/column derive from r, so a stalled word stays stable
    // while r holds; the grid is frozen because all lanes are idle here.
    // -------------------------------------------------------------------------
    always_comb begin
        res_data = arr_c[int'(r) * ACC_W +: ACC_W];
        res_row  = KW'(int'(r) / N);
        res_col  = KW'(int'(r) % N);
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//   Drives systolic_ctrl (N=4 and N=1 instances) against a behavioural PE
//   grid fed from operand matrices through lane_en/lane_k. A golden matrix
//   product fills a scoreboard that the result monitor drains.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 2 * W;
    localparam int KW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- N=4 DUT ----------------
    logic               rst, start, res_ready;
    logic               busy, done, arr_clr, res_valid;
    logic [N-1:0]       lane_en;
    logic [N*KW-1:0]    lane_k;
    logic [N*N*AW-1:0]  arr_c;
    logic [AW-1:0]      res_data;
    logic [KW-1:0]      res_row, res_col;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]        perf, perf1;
`endif

    systolic_ctrl #(.N(N), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .arr_clr(arr_clr), .lane_en(lane_en), .lane_k(lane_k), .arr_c(arr_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .perf_cycles(perf)
`endif
    );

    // ---------------- N=1 DUT ----------------
    logic        s1_start, s1_ready;
    logic        busy1, done1, arr_clr1, res_valid1;
    logic [0:0]  lane_en1, lane_k1, res_row1, res_col1;
    logic [AW-1:0] arr_c1, res_data1;

    systolic_ctrl #(.N(1), .WIDTH(W)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .busy(busy1), .done(done1),
        .arr_clr(arr_clr1), .lane_en(lane_en1), .lane_k(lane_k1), .arr_c(arr_c1),
        .res_valid(res_valid1), .res_ready(s1_ready), .res_data(res_data1),
        .res_row(res_row1), .res_col(res_col1)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .perf_cycles(perf1)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- operand matrices and PE grid model ----------------
    logic [W-1:0]  ma [N][N];
    logic [W-1:0]  mb [N][N];
    logic [AW-1:0] acc [N][N];
    logic [W-1:0]  ar [N][N];
    logic [W-1:0]  br [N][N];

    function automatic logic [W-1:0] a_at(input int r, input int c);
        if (c == 0) return lane_en[r] ? ma[r][lane_k[r*KW +: KW]] : '0;
        return ar[r][c-1];
    endfunction

    function automatic logic [W-1:0] b_at(input int r, input int c);
        if (r == 0) return lane_en[c] ? mb[lane_k[c*KW +: KW]][c] : '0;
        return br[r-1][c];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rst || arr_clr) begin
                    acc[r][c] <= '0;
                    ar[r][c]  <= '0;
                    br[r][c]  <= '0;
                end else begin
                    acc[r][c] <= acc[r][c] + AW'(a_at(r, c)) * AW'(b_at(r, c));
                    ar[r][c]  <= a_at(r, c);
                    br[r][c]  <= b_at(r, c);
                end
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                arr_c[(r*N + c)*AW +: AW] = acc[r][c];
    end

    // Single-PE grid for the N=1 instance, operands 5 and 7.
    logic [W-1:0] a1 = 8'd5, b1 = 8'd7;
    always @(posedge clk) begin
        if (rst || arr_clr1) arr_c1 <= '0;
        else if (lane_en1[0]) arr_c1 <= arr_c1 + AW'(a1) * AW'(b1);
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct packed {
        logic [KW-1:0] row;
        logic [KW-1:0] col;
        logic [AW-1:0] data;
    } word_t;

    word_t sb[$];
    word_t w;
    int    last_hs   = 0;
    bit    stall_prev = 0;
    logic [2*KW+AW-1:0] stall_word;

    always @(negedge clk) begin
        if (res_valid) begin
            if (stall_prev)
                check("stall_hold", 64'({res_row, res_col, res_data}), 64'(stall_word));
            if (res_ready) begin
                stall_prev = 0;
                last_hs    = cyc;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got row %0d col %0d data 0x%0h, want no word",
                             res_row, res_col, res_data);
                end else begin
                    w = sb.pop_front();
                    check("res_word", 64'({res_row, res_col, res_data}), 64'(w));
                end
            end else begin
                stall_prev = 1;
                stall_word = {res_row, res_col, res_data};
            end
        end else begin
            stall_prev = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int ak, input int bk);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (ak)
                    0:       ma[r][c] = (r == c) ? 8'd1 : 8'd0;
                    1:       ma[r][c] = 8'd2;
                    2:       ma[r][c] = 8'hFF;
                    default: ma[r][c] = 8'($urandom_range(0, 255));
                endcase
                case (bk)
                    0:       mb[r][c] = 8'(r*N + c + 1);
                    1:       mb[r][c] = 8'd3;
                    2:       mb[r][c] = 8'hFF;
                    default: mb[r][c] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Golden product, pushed in row-major order.
    task automatic push_expected();
        word_t e;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [AW-1:0] s = '0;
                for (int k = 0; k < N; k++) s = s + AW'(ma[r][k]) * AW'(mb[k][c]);
                e.row  = KW'(r);
                e.col  = KW'(c);
                e.data = s;
                sb.push_back(e);
            end
        end
    endtask

    // Expected {busy, arr_clr, res_valid, done, lane_en, lane_k} for cycle c
    // of a run, counting the cycle that presents start as cycle 1.
    function automatic logic [15:0] exp_ctrl(input int c);
        logic [N-1:0]    en = '0;
        logic [N*KW-1:0] k  = '0;
        int t = c - 3;
        for (int i = 0; i < N; i++) begin
            if (c >= 3 && c <= 2 + 2*N - 1 && i <= t && t < i + N) begin
                en[i]          = 1'b1;
                k[i*KW +: KW]  = KW'(t - i);
            end
        end
        return {(c >= 2), (c == 2), (c >= 3*N + 1), 1'b0, en, k};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_arr_clr"},   64'(arr_clr),   64'd0);
        check({tag, "_lane_en"},   64'(lane_en),   64'd0);
        check({tag, "_lane_k"},    64'(lane_k),    64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_row_col"},   64'({res_row, res_col}), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    typedef struct {
        int ak;       // A pattern: 0 identity, 1 all 2, 2 all FF, 3 random
        int bk;       // B pattern: 0 1..16, 1 all 3, 2 all FF, 3 random
        int rk;       // ready: 0 always high, 1 toggling with a 5-cycle stall at r=6
        int sk;       // 0 single start, 1 extra start pulses in FEED and READOUT
        int exp_lat;  // cycle of first res_valid, start cycle counted as 1
    } vec_t;

    task automatic run_case(input vec_t v);
        int first_valid  = 0;
        bit got_done     = 0;
        bit stalled_once = 0;
        int stall_left   = 0;
        bit tog          = 1;
        load(v.ak, v.bk);
        push_expected();
        @(posedge clk); #1;
        start     = 1'b1;
        res_ready = (v.rk == 0);
        for (int c = 1; c <= 300 && !got_done; c++) begin
            @(negedge clk);
            if (c <= v.exp_lat)
                check($sformatf("ctrl_c%0d", c),
                      64'({busy, arr_clr, res_valid, done, lane_en, lane_k}), 64'(exp_ctrl(c)));
            if (res_valid && first_valid == 0) first_valid = c;
            if (done) begin
                got_done = 1;
                check("done_after_last", 64'(cyc - last_hs), 64'd1);
                check("idle_at_done", 64'({busy, res_valid}), 64'd0);
                check("sb_drained", 64'(sb.size()), 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
                check("perf_cycles", 64'(perf), 64'(c - 2));
`endif
            end
            @(posedge clk); #1;
            start = (v.sk == 1) && (c + 1 == 5 || c + 1 == 15);
            if (v.rk == 0) begin
                res_ready = 1'b1;
            end else if (stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else if (!stalled_once && res_valid && res_row == 2'd1 && res_col == 2'd2) begin
                stalled_once = 1;
                stall_left   = 4;
                res_ready    = 1'b0;
            end else begin
                res_ready = tog;
                tog       = !tog;
            end
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("latency", 64'(first_valid), 64'(v.exp_lat));
        start     = 1'b0;
        res_ready = 1'b1;
    endtask

    typedef struct {
        logic [4:0]    ctrl;  // {busy, arr_clr, lane_en, res_valid, done}
        logic [AW-1:0] data;
    } n1_t;

    // ---------------- main sequence ----------------
    vec_t vecs[5];
    n1_t  n1_tab[6];

    initial begin
        vecs[0] = '{ak: 0, bk: 0, rk: 0, sk: 0, exp_lat: 3*N + 1};
        vecs[1] = '{ak: 1, bk: 1, rk: 0, sk: 0, exp_lat: 3*N + 1};
        vecs[2] = '{ak: 2, bk: 2, rk: 0, sk: 0, exp_lat: 3*N + 1};
        vecs[3] = '{ak: 3, bk: 3, rk: 1, sk: 0, exp_lat: 3*N + 1};
        vecs[4] = '{ak: 3, bk: 0, rk: 0, sk: 1, exp_lat: 3*N + 1};

        n1_tab[0] = '{ctrl: 5'b00000, data: '0};
        n1_tab[1] = '{ctrl: 5'b11000, data: '0};
        n1_tab[2] = '{ctrl: 5'b10100, data: '0};
        n1_tab[3] = '{ctrl: 5'b10010, data: 16'd35};
        n1_tab[4] = '{ctrl: 5'b00001, data: '0};
        n1_tab[5] = '{ctrl: 5'b00000, data: '0};

        rst = 1'b1; start = 1'b0; res_ready = 1'b1; s1_start = 1'b0; s1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_case(vecs[i]);
            repeat (2) @(posedge clk);
        end

        // start held high across done: second run begins with CLEAR next cycle.
        #1;
        load(3, 3);
        push_expected();
        start = 1'b1;
        wait_done("held_run1");
        push_expected();
        @(negedge clk);
        check("restart_clear", 64'({busy, arr_clr}), 64'b11);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("held_run2");
        check("held_sb_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);

        // Reset during FEED at t=3, then a clean run.
        #1;
        load(3, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("feed_t3_lanes", 64'({lane_en, lane_k}), 64'({4'b1111, 8'h1B}));
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_case('{ak: 3, bk: 3, rk: 0, sk: 0, exp_lat: 3*N + 1});
        repeat (2) @(posedge clk);

        // N=1 instance: CLEAR, FEED(1), READOUT, done.
        #1;
        s1_start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("n1_ctrl_c%0d", c + 1),
                  64'({busy1, arr_clr1, lane_en1, res_valid1, done1}), 64'(n1_tab[c].ctrl));
            check($sformatf("n1_lane_k_c%0d", c + 1), 64'(lane_k1), 64'd0);
            if (n1_tab[c].ctrl[1]) begin
                check("n1_data", 64'(res_data1), 64'(n1_tab[c].data));
                check("n1_row_col", 64'({res_row1, res_col1}), 64'd0);
            end
            @(posedge clk); #1;
            s1_start = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
